// File: rtl/hero_write_rx.sv
// Receives HERO write beats, frames them into transactions and buffers them for a consumer.
// Overflow and over-length transactions are cut short with an error terminator entry.
module hero_write_rx #(
  parameter int DEPTH     = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [40:0] hero_in,
  output logic        rd_vld,
  input  logic        rd_rdy,
  output logic [35:0] rd_dat,
  output logic        rd_last,
  output logic        rd_err,
  output logic        ovf_err,
  output logic        len_err,
  output logic        proto_err,
  output logic [15:0] xact_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_XACT, S_DROP} state_t;

  // hero_in layout: {cycle_type[3:0], wdat[35:0], clk_en}
  logic [3:0]  cycle_type;
  logic [35:0] wdat;
  logic        clk_en;
  assign cycle_type = hero_in[40:37];
  assign wdat       = hero_in[36:1];
  assign clk_en     = hero_in[0];

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [37:0]   mem [DEPTH];
  logic [37:0]   head;

  logic        is_valid, is_done, is_bad, rd_fire;
  logic        wr_en, wr_last, wr_err, xact_inc;
  logic [35:0] wr_dat;
  logic        ovf_nxt, len_nxt;

  assign is_valid = clk_en && (cycle_type == 4'd1);
  assign is_done  = clk_en && (cycle_type == 4'd2);
  assign is_bad   = clk_en && (cycle_type > 4'd2);

  assign rd_vld  = (count != '0);
  assign rd_fire = rd_vld && rd_rdy;
  assign head    = mem[rd_ptr];
  assign rd_dat  = rd_vld ? head[37:2] : '0;
  assign rd_last = rd_vld && head[1];
  assign rd_err  = rd_vld && head[0];

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    wr_en     = 1'b0;
    wr_dat    = wdat;
    wr_last   = 1'b0;
    wr_err    = 1'b0;
    xact_inc  = 1'b0;
    ovf_nxt   = 1'b0;
    len_nxt   = 1'b0;
    case (state)
      S_IDLE, S_XACT: begin
        if (is_valid || is_done) begin
          // Overflow is judged on the pre-read count; the last slot is kept for the terminator.
          if (count == CW'(DEPTH - 1)) begin
            wr_en     = 1'b1;
            wr_dat    = '0;
            wr_last   = 1'b1;
            wr_err    = 1'b1;
            ovf_nxt   = 1'b1;
            beat_nxt  = '0;
            state_nxt = is_valid ? S_DROP : S_IDLE;
          end else if (count == CW'(DEPTH)) begin
            ovf_nxt   = 1'b1;
            beat_nxt  = '0;
            state_nxt = is_valid ? S_DROP : S_IDLE;
          end else if (is_done) begin
            wr_en     = 1'b1;
            wr_last   = 1'b1;
            xact_inc  = 1'b1;
            beat_nxt  = '0;
            state_nxt = S_IDLE;
          end else if (beat_cnt == BW'(MAX_BEATS - 1)) begin
            wr_en     = 1'b1;
            wr_last   = 1'b1;
            wr_err    = 1'b1;
            len_nxt   = 1'b1;
            beat_nxt  = '0;
            state_nxt = S_DROP;
          end else begin
            wr_en     = 1'b1;
            beat_nxt  = beat_cnt + BW'(1);
            state_nxt = S_XACT;
          end
        end
      end
      S_DROP: begin
        if (is_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      beat_cnt  <= '0;
      xact_cnt  <= '0;
      ovf_err   <= 1'b0;
      len_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      ovf_err   <= ovf_nxt;
      len_err   <= len_nxt;
      proto_err <= is_bad;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      if (xact_inc) xact_cnt <= xact_cnt + 16'd1;
      case ({wr_en, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage carries no reset; visibility is governed by count.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {wr_dat, wr_last, wr_err};
  end
endmodule

// File: tb/tb_hero_write_rx.sv
// Directed bench for hero_write_rx: framing, overflow, length, protocol and reset behaviour.
module tb_hero_write_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic [40:0] hero_in;
  logic        rd_rdy;

  logic        rd_vld, rd_last, rd_err, ovf_err, len_err, proto_err;
  logic [35:0] rd_dat;
  logic [15:0] xact_cnt;
  logic        b_vld, b_last, b_err, b_ovf, b_len, b_proto;
  logic [35:0] b_dat;
  logic [15:0] b_xact;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hero_write_rx u_dut (
    .clk(clk), .rst(rst), .hero_in(hero_in),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_dat(rd_dat), .rd_last(rd_last), .rd_err(rd_err),
    .ovf_err(ovf_err), .len_err(len_err), .proto_err(proto_err), .xact_cnt(xact_cnt)
  );

  // Long transactions allowed so the buffer limit, not the length limit, is exercised.
  hero_write_rx #(.DEPTH(16), .MAX_BEATS(32)) u_big (
    .clk(clk), .rst(rst), .hero_in(hero_in),
    .rd_vld(b_vld), .rd_rdy(rd_rdy), .rd_dat(b_dat), .rd_last(b_last), .rd_err(b_err),
    .ovf_err(b_ovf), .len_err(b_len), .proto_err(b_proto), .xact_cnt(b_xact)
  );

  task automatic beat(input logic [3:0] ct, input logic [35:0] dat, input logic en);
    hero_in = {ct, dat, en};
    @(posedge clk); #1;
    hero_in = '0;
  endtask

  task automatic idle_cycle();
    hero_in = '0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; hero_in = '0; rd_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_rdy = 1'b0;
    hero_in = {4'd1, 36'h123, 1'b1};
    @(posedge clk); #1;
    n_vec++;
    if ({rd_vld, rd_dat, rd_last, rd_err} !== 38'h0) begin
      n_err++; $display("FAIL reset_rd: got vld=%b dat=%h last=%b err=%b want all 0", rd_vld, rd_dat, rd_last, rd_err);
    end
    n_vec++;
    if ({xact_cnt, ovf_err, len_err, proto_err} !== 19'h0) begin
      n_err++; $display("FAIL reset_ctl: got xact=%0d ovf=%b len=%b proto=%b want all 0", xact_cnt, ovf_err, len_err, proto_err);
    end
    rst = 1'b0; hero_in = '0;
  endtask

  task automatic test_basic();
    do_reset();
    rd_rdy = 1'b1;
    beat(4'd1, 36'hA, 1'b1);
    n_vec++;
    if (!(rd_vld === 1'b1 && rd_dat === 36'hA && rd_last === 1'b0)) begin
      n_err++; $display("FAIL basic_A: got vld=%b dat=%h last=%b want 1 A 0", rd_vld, rd_dat, rd_last);
    end
    beat(4'd1, 36'hB, 1'b1);
    n_vec++;
    if (!(rd_vld === 1'b1 && rd_dat === 36'hB && rd_last === 1'b0)) begin
      n_err++; $display("FAIL basic_B: got vld=%b dat=%h last=%b want 1 B 0", rd_vld, rd_dat, rd_last);
    end
    beat(4'd2, 36'hC, 1'b1);
    n_vec++;
    if (!(rd_vld === 1'b1 && rd_dat === 36'hC && rd_last === 1'b1 && rd_err === 1'b0)) begin
      n_err++; $display("FAIL basic_C: got vld=%b dat=%h last=%b err=%b want 1 C 1 0", rd_vld, rd_dat, rd_last, rd_err);
    end
    n_vec++;
    if (xact_cnt !== 16'd1) begin
      n_err++; $display("FAIL basic_xact: got %0d want 1", xact_cnt);
    end
    idle_cycle();
    n_vec++;
    if (rd_vld !== 1'b0) begin
      n_err++; $display("FAIL basic_empty: got vld=%b want 0", rd_vld);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      beat(4'd1, 36'(i + 1), 1'b1);
      if (i == 15) begin
        n_vec++;
        if (b_ovf !== 1'b1) begin
          n_err++; $display("FAIL ovf_pulse: got %b want 1", b_ovf);
        end
      end
    end
    beat(4'd2, 36'h55, 1'b1);
    n_vec++;
    if (b_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_once: got %b want 0 after DONE", b_ovf);
    end
    n_vec++;
    if (!(b_vld === 1'b1 && b_dat === 36'h1)) begin
      n_err++; $display("FAIL ovf_hold: got vld=%b dat=%h want 1 1", b_vld, b_dat);
    end
    rd_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (k < 15) begin
        if (!(b_vld === 1'b1 && b_dat === 36'(k + 1) && b_last === 1'b0 && b_err === 1'b0)) begin
          n_err++; $display("FAIL ovf_entry%0d: got vld=%b dat=%h last=%b err=%b want 1 %h 0 0", k, b_vld, b_dat, b_last, b_err, k + 1);
        end
      end else if (!(b_vld === 1'b1 && b_dat === 36'h0 && b_last === 1'b1 && b_err === 1'b1)) begin
        n_err++; $display("FAIL ovf_term: got vld=%b dat=%h last=%b err=%b want 1 0 1 1", b_vld, b_dat, b_last, b_err);
      end
      idle_cycle();
    end
    n_vec++;
    if (!(b_vld === 1'b0 && b_xact === 16'd0)) begin
      n_err++; $display("FAIL ovf_end: got vld=%b xact=%0d want 0 0", b_vld, b_xact);
    end
  endtask

  task automatic test_length();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      beat(4'd1, 36'h100 + 36'(i), 1'b1);
      if (i == 8 || i == 9) begin
        n_vec++;
        if (len_err !== (i == 8)) begin
          n_err++; $display("FAIL len_pulse%0d: got %b want %b", i, len_err, i == 8);
        end
      end
    end
    beat(4'd2, 36'h1FF, 1'b1);
    rd_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (!(rd_vld === 1'b1 && rd_dat === 36'h100 + 36'(k) && rd_last === (k == 8) && rd_err === (k == 8))) begin
        n_err++; $display("FAIL len_entry%0d: got vld=%b dat=%h last=%b err=%b", k, rd_vld, rd_dat, rd_last, rd_err);
      end
      idle_cycle();
    end
    n_vec++;
    if (!(rd_vld === 1'b0 && xact_cnt === 16'd0)) begin
      n_err++; $display("FAIL len_end: got vld=%b xact=%0d want 0 0", rd_vld, xact_cnt);
    end
  endtask

  task automatic test_proto();
    do_reset();
    beat(4'd1, 36'h21, 1'b1);
    beat(4'd5, 36'h99, 1'b1);
    n_vec++;
    if (proto_err !== 1'b1) begin
      n_err++; $display("FAIL proto_pulse: got %b want 1", proto_err);
    end
    beat(4'd1, 36'h77, 1'b0);
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL proto_once: got %b want 0", proto_err);
    end
    beat(4'd5, 36'h99, 1'b0);
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL proto_gated: got %b want 0", proto_err);
    end
    beat(4'd2, 36'h22, 1'b1);
    rd_rdy = 1'b1;
    n_vec++;
    if (!(rd_dat === 36'h21 && rd_last === 1'b0)) begin
      n_err++; $display("FAIL proto_e0: got dat=%h last=%b want 21 0", rd_dat, rd_last);
    end
    idle_cycle();
    n_vec++;
    if (!(rd_vld === 1'b1 && rd_dat === 36'h22 && rd_last === 1'b1 && rd_err === 1'b0)) begin
      n_err++; $display("FAIL proto_e1: got vld=%b dat=%h last=%b err=%b want 1 22 1 0", rd_vld, rd_dat, rd_last, rd_err);
    end
    idle_cycle();
    n_vec++;
    if (!(rd_vld === 1'b0 && xact_cnt === 16'd1)) begin
      n_err++; $display("FAIL proto_end: got vld=%b xact=%0d want 0 1", rd_vld, xact_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    beat(4'd1, 36'h31, 1'b1);
    beat(4'd1, 36'h32, 1'b1);
    rst = 1'b1;
    beat(4'd1, 36'h33, 1'b1);
    n_vec++;
    if (rd_vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid_vld: got %b want 0", rd_vld);
    end
    rst = 1'b0;
    beat(4'd2, 36'h1, 1'b1);
    n_vec++;
    if (!(rd_vld === 1'b1 && rd_dat === 36'h1 && rd_last === 1'b1 && rd_err === 1'b0)) begin
      n_err++; $display("FAIL rstmid_entry: got vld=%b dat=%h last=%b err=%b want 1 1 1 0", rd_vld, rd_dat, rd_last, rd_err);
    end
    rd_rdy = 1'b1;
    idle_cycle();
    n_vec++;
    if (!(rd_vld === 1'b0 && xact_cnt === 16'd1)) begin
      n_err++; $display("FAIL rstmid_end: got vld=%b xact=%0d want 0 1", rd_vld, xact_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_rdy = 1'b1;
    beat(4'd2, 36'h5, 1'b1);
    n_vec++;
    if (!(rd_dat === 36'h5 && rd_last === 1'b1 && xact_cnt === 16'd1)) begin
      n_err++; $display("FAIL b2b_first: got dat=%h last=%b xact=%0d want 5 1 1", rd_dat, rd_last, xact_cnt);
    end
    beat(4'd2, 36'h6, 1'b1);
    n_vec++;
    if (!(rd_dat === 36'h6 && rd_last === 1'b1 && xact_cnt === 16'd2)) begin
      n_err++; $display("FAIL b2b_second: got dat=%h last=%b xact=%0d want 6 1 2", rd_dat, rd_last, xact_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; hero_in = '0; rd_rdy = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_length();
    test_proto();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
